// File: rtl/nfu_1_mult_array.sv
// NFU-1 stage: TN x TN signed multiplier array with valid/ready flow control.
// Multiply happens in the first stage; round/saturate in the last.
module nfu_1_mult_array #(
  parameter int BIT_WIDTH   = 16,
  parameter int TN          = 16,
  parameter int PIPE_STAGES = 3,
  parameter int FRAC_BITS   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_mode,
  input  logic                      i_bcast,
  input  logic [BIT_WIDTH*TN*TN-1:0] i_inputs,
  input  logic [BIT_WIDTH*TN*TN-1:0] i_synapses,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [BIT_WIDTH*TN*TN-1:0] o_results,
  output logic [3:0]                o_inflight
);

  localparam int BW   = BIT_WIDTH;
  localparam int N    = TN * TN;
  localparam int PW   = 2 * BW;
  localparam int LAST = PIPE_STAGES - 1;
  localparam logic [PW:0] RND = (PW+1)'((1 << FRAC_BITS) >> 1);

  logic                   advance;
  logic                   accept;
  logic                   retire;
  logic [PIPE_STAGES-1:0] vld;
  logic [N*PW-1:0]        prodC;
  logic [N*PW-1:0]        finProd;
  logic                   finMode;
  logic [N*BW-1:0]        resC;

  function automatic logic [BW-1:0] fixRound(
    input logic [PW-1:0] p
  );
    logic signed [PW:0] q;
    logic [BW-1:0]      r;
    q = $signed({p[PW-1], p}) + $signed(RND);
    q = q >>> FRAC_BITS;
    if (&q[PW:BW-1] || ~|q[PW:BW-1])
      r = q[BW-1:0];
    else if (q[PW])
      r = {1'b1, {(BW-1){1'b0}}};
    else
      r = {1'b0, {(BW-1){1'b1}}};
    return r;
  endfunction

  assign o_valid = vld[LAST];
  assign advance = !o_valid | i_ready;
  assign o_ready = advance;
  assign accept  = i_valid & advance;
  assign retire  = o_valid & i_ready;

  for (genvar n = 0; n < N; n++) begin : gLane
    localparam int J = n % TN;
    logic signed [BW-1:0] a;
    logic signed [BW-1:0] s;
    // broadcast reuses row 0, lane J for every row
    assign a = i_bcast ? i_inputs[J*BW +: BW]
                       : i_inputs[n*BW +: BW];
    assign s = i_synapses[n*BW +: BW];
    assign prodC[n*PW +: PW] = a * s;
    assign resC[n*BW +: BW] = finMode
      ? fixRound(finProd[n*PW +: PW])
      : finProd[n*PW +: BW];
  end

  if (PIPE_STAGES > 1) begin : gDeep
    logic [N*PW-1:0]        prodR [PIPE_STAGES-1];
    logic [PIPE_STAGES-2:0] modeR;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < PIPE_STAGES-1; k++)
          prodR[k] <= '0;
        modeR <= '0;
      end else if (advance) begin
        prodR[0] <= prodC;
        modeR[0] <= i_mode;
        for (int k = 1; k < PIPE_STAGES-1; k++) begin
          prodR[k] <= prodR[k-1];
          modeR[k] <= modeR[k-1];
        end
      end
    end

    assign finProd = prodR[PIPE_STAGES-2];
    assign finMode = modeR[PIPE_STAGES-2];
  end else begin : gShallow
    assign finProd = prodC;
    assign finMode = i_mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= '0;
      o_results  <= '0;
      o_inflight <= '0;
    end else begin
      if (advance) begin
        vld[0] <= accept;
        for (int k = 1; k < PIPE_STAGES; k++)
          vld[k] <= vld[k-1];
        o_results <= resC;
      end
      if (accept && !retire)
        o_inflight <= o_inflight + 4'd1;
      else if (retire && !accept)
        o_inflight <= o_inflight - 4'd1;
    end
  end

endmodule

// File: tb/tb_nfu_1_mult_array.sv
// Bench for nfu_1_mult_array: directed table, hand sequences,
// and random traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_nfu_1_mult_array;

  localparam int BW = 16;
  localparam int TN = 4;
  localparam int PS = 3;
  localparam int FB = 10;
  localparam int N  = TN * TN;
  localparam int NB = BW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic          i_mode;
  logic          i_bcast;
  logic [NB-1:0] i_inputs;
  logic [NB-1:0] i_synapses;
  logic          o_valid;
  logic          i_ready;
  logic [NB-1:0] o_results;
  logic [3:0]    o_inflight;

  int checks = 0;
  int errors = 0;
  int retired = 0;
  logic [NB-1:0] sbq [$];
  bit            prevStall = 0;
  logic [NB-1:0] prevRes = '0;

  typedef struct {
    bit          mode;
    logic [15:0] a;
    logic [15:0] s;
    logic [15:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  nfu_1_mult_array #(
    .BIT_WIDTH(BW), .TN(TN), .PIPE_STAGES(PS), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_bcast(i_bcast),
    .i_inputs(i_inputs), .i_synapses(i_synapses),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_results(o_results), .o_inflight(o_inflight)
  );

  function automatic logic [NB-1:0] model(
    input bit mode, input bit bc,
    input logic [NB-1:0] in, input logic [NB-1:0] sy
  );
    logic [NB-1:0] r;
    longint a, s, p, q, d;
    int src;
    r = '0;
    d = longint'(1) << FB;
    for (int row = 0; row < TN; row++) begin
      for (int j = 0; j < TN; j++) begin
        src = bc ? j : row*TN + j;
        a = $signed(in[src*BW +: BW]);
        s = $signed(sy[(row*TN+j)*BW +: BW]);
        p = a * s;
        if (!mode) begin
          q = p;
        end else begin
          q = p + d / 2;
          if (q >= 0) q = q / d;
          else q = -((-q + d - 1) / d);
          if (q > 32767) q = 32767;
          if (q < -32768) q = -32768;
        end
        r[(row*TN+j)*BW +: BW] = q[BW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [NB-1:0] rndVec();
    logic [NB-1:0] v;
    for (int n = 0; n < N; n++) v[n*BW +: BW] = pick();
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [NB-1:0] act,
                     input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkInt(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 20);
    if (!o_valid) chkInt("wait o_valid timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chkInt("drain queue empty", sbq.size(), 0);
  endtask

  // scoreboard and stall monitor
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prevStall = 0;
    end else begin
      if (o_valid && i_ready) begin
        retired++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious result: got %h expected none", o_results);
        end else begin
          chk("scoreboard", o_results, sbq.pop_front());
        end
      end
      checks++;
      if (o_inflight > 4'(PS)) begin
        errors++;
        $display("FAIL inflight bound: got %0d expected <= %0d", o_inflight, PS);
      end
      if (o_valid && !i_ready) begin
        chkInt("stall o_ready", int'(o_ready), 0);
        if (prevStall) chk("stall hold", o_results, prevRes);
      end
      prevStall = o_valid && !i_ready;
      prevRes   = o_results;
      if (i_valid && o_ready)
        sbq.push_back(model(i_mode, i_bcast, i_inputs, i_synapses));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sent;
    int r0;
    logic [NB-1:0] expV;

    tbl[0] = '{1'b1, 16'h0400, 16'h0800, 16'h0800, "fx unity"};
    tbl[1] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, "fx sat pos"};
    tbl[2] = '{1'b1, 16'hFC00, 16'h7FFF, 16'h8001, "fx neg"};
    tbl[3] = '{1'b1, 16'h8000, 16'h8000, 16'h7FFF, "fx min*min"};
    tbl[4] = '{1'b0, 16'h012C, 16'h012C, 16'h5F90, "int wrap"};
    tbl[5] = '{1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, "int neg"};
    tbl[6] = '{1'b1, 16'h0001, 16'h0200, 16'h0001, "fx half up"};
    tbl[7] = '{1'b1, 16'hFFFF, 16'h0200, 16'h0000, "fx neg half"};
    tbl[8] = '{1'b1, 16'h0200, 16'h0400, 16'h0200, "fx half*one"};
    tbl[9] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, "fx tiny neg"};

    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_mode = 1'b0;
    i_bcast = 1'b0;
    i_inputs = '0;
    i_synapses = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkInt("reset o_valid", int'(o_valid), 0);
    chkInt("reset o_inflight", int'(o_inflight), 0);
    chk("reset o_results", o_results, '0);
    chkInt("reset o_ready", int'(o_ready), 1);
    @(posedge clk); #1;

    // single transaction latency and occupancy
    i_mode = 1'b1;
    i_inputs = {N{16'h0400}};
    i_synapses = {N{16'h0800}};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chkInt($sformatf("t1 o_valid c%0d", k), int'(o_valid), int'(k == 3));
      chkInt($sformatf("t1 inflight c%0d", k), int'(o_inflight), k <= 3 ? 1 : 0);
      if (k == 3) chk("t1 result", o_results, {N{16'h0800}});
    end
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      i_mode = tbl[i].mode;
      i_bcast = 1'b0;
      i_inputs = {N{tbl[i].a}};
      i_synapses = {N{tbl[i].s}};
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      waitValid(lat);
      chkInt({tbl[i].nm, " latency"}, lat, PS);
      chk(tbl[i].nm, o_results, {N{tbl[i].exp}});
      @(posedge clk); #1;
    end

    // broadcast: rows 1..3 carry junk that must be ignored
    i_mode = 1'b0;
    i_bcast = 1'b1;
    i_inputs = {N{16'h7777}};
    for (int j = 0; j < TN; j++) i_inputs[j*BW +: BW] = 16'(j + 1);
    i_synapses = {N{16'h0001}};
    for (int n = 0; n < N; n++) expV[n*BW +: BW] = 16'(n % TN + 1);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_bcast = 1'b0;
    waitValid(lat);
    chk("bcast", o_results, expV);
    @(posedge clk); #1;

    // backpressure window during a 10-deep stream
    r0 = retired;
    sent = 0;
    for (int cyc = 0; sent < 10 && cyc < 100; cyc++) begin
      i_ready = !(cyc >= 4 && cyc <= 8);
      i_valid = 1'b1;
      i_mode = 1'($urandom);
      i_bcast = 1'($urandom);
      i_inputs = rndVec();
      i_synapses = rndVec();
      @(negedge clk);
      if (o_ready) sent++;
      @(posedge clk); #1;
    end
    drain();
    chkInt("bp retired count", retired - r0, 10);

    // reset with three transactions in flight
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_mode = 1'($urandom);
      i_inputs = rndVec();
      i_synapses = rndVec();
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkInt("post-reset o_valid", int'(o_valid), 0);
    chkInt("post-reset inflight", int'(o_inflight), 0);
    @(posedge clk); #1;
    i_mode = 1'b1;
    i_inputs = rndVec();
    i_synapses = rndVec();
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    waitValid(lat);
    chkInt("post-reset latency", lat, PS);
    @(posedge clk); #1;

    // random traffic with random bubbles and stalls
    for (int cyc = 0; cyc < 300; cyc++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 8);
      i_mode = 1'($urandom);
      i_bcast = 1'($urandom);
      i_inputs = rndVec();
      i_synapses = rndVec();
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
